phase_seq: RTL and testbench
============================

Name: phase_seq

Overview:
- Parametrised multi-cycle phase sequencer; successor to the fixed 5-phase ring counter that drives fetch/read/execute/memory/write in the processor.
- Produces a one-hot phase vector of configurable length.
- Adds per-instruction phase skipping, stall hold, restart/flush, completion strobe and a one-hot integrity check.
- Sits between the decoder (which supplies skip/stall/restart) and all phase-gated datapath enables.

Parameters:
- NPHASE, 5, number of phases (legal range 2..16); bit 0 is always the fetch phase.
- CNTW, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- stall  input  1  hold current phase this cycle.
- restart  input  1  abandon current instruction; go to phase 0 next cycle.
- skip  input  NPHASE  phases to bypass for the current instruction; bit 0 ignored.
- phase  output  NPHASE  registered one-hot current phase.
- first  output  1  phase[0] active (combinational from the phase register).
- last  output  1  current instruction completes this cycle (combinational).
- err  output  1  sticky flag, set when the phase register is found not one-hot.
- retired  output  CNTW  completed-instruction count (optional feature only).

Behaviour:
- Reset: synchronous, active-high. On a clk edge with rst=1: phase=1 (only bit 0 set), err=0, retired=0. first=1 and last=0 follow from that state.
- Priority each edge: rst > illegal-state recovery > restart > stall > advance.
- Advance (stall=0, restart=0):
  - Next phase is the lowest index j > current index i with skip[j]=0.
  - If no such j exists, phase wraps to 0.
  - skip is sampled combinationally every cycle; the decoder may change it as the IR becomes valid.
- Stall: phase is unchanged and last=0. Stall may last any number of cycles.
- Restart: next phase=0 regardless of stall; last=0 in that cycle (restart is not a completion).
  - Restart while already in phase 0 keeps phase 0.
- last = 1 when stall=0, restart=0, rst=0, the phase is one-hot, and the advance wraps to phase 0. With NPHASE=5 and skip=0, last is high during phase[4].
- Single-phase instruction: if skip[NPHASE-1:1] are all 1 in phase 0, then last=1 in phase 0 and phase stays 0 (wraps onto itself).
- Illegal state (phase zero or more than one bit set):
  - Next phase=0 and err is set to 1.
  - err stays 1 until rst.
  - last=0 in that cycle.
- Latency:
  - phase changes exactly one cycle after the decision inputs.
  - first, last and err read the registered state; last also reads the same-cycle inputs.
- Wrap-around only ever returns to phase 0; no other phase is re-entered without passing through phase 0.

Optional Feature:
- Macro: PHASE_SEQ_RETIRE_CNT_EN.
- Defined:
  - retired increments by 1 on every edge where last=1.
  - Wraps modulo 2^CNTW.
  - Cleared by rst; unaffected by stall and restart.
- Undefined:
  - retired is driven constant 0.
  - No counter flops are synthesised; all other behaviour is identical.

Test Plan:
- Reset then free-run (NPHASE=5, skip=0, stall=0): phase sequence 1,2,4,8,16,1; last=1 only while phase=16; first=1 only while phase=1.
- skip=5'b01000 (skip memory phase): sequence 1,2,4,16,1; retired increases by 1 per 4 cycles when PHASE_SEQ_RETIRE_CNT_EN is defined.
- stall=1 for 3 cycles in phase=4: phase stays 4 for those 3 cycles and last=0; after release, phase=8 on the next edge.
- restart=1 during phase=8 with stall=1 simultaneously: phase=1 next edge; last=0; retired unchanged.
- Force phase=5'b00110 by force/release: next edge phase=1 and err=1; err holds through 10 normal cycles; rst clears it to 0.
- CNTW=4 with counter enabled, 17 full instructions: retired=1 (wrapped); with macro undefined, retired=0 throughout.

Source files
------------

// File: rtl/phase_seq.sv
// phase_seq -- parametrised one-hot phase sequencer.
//
// Steps a one-hot phase register through NPHASE phases (bit 0 = fetch).
// Phases flagged in skip are bypassed for the current instruction. When
// no unskipped phase remains above the current one, the sequencer wraps
// to phase 0 and signals completion. stall holds the current phase.
// restart returns to phase 0. A corrupted (non one-hot) phase register
// also returns to phase 0 and sets a sticky error flag.
//
// Optional feature macro: PHASE_SEQ_RETIRE_CNT_EN
//   defined   : retired counts completed instructions (mod 2^CNTW)
//   undefined : retired is tied to zero and no counter is built
//
// Parameters:
//   NPHASE  number of phases, 2..16
//   CNTW    width of the retired-instruction counter
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   stall    hold the current phase this cycle
//   restart  abandon the instruction, go to phase 0 next cycle
//   skip     phases to bypass for this instruction (bit 0 ignored)
//   phase    registered one-hot current phase
//   first    phase 0 is active
//   last     the instruction completes this cycle
//   err      sticky flag: phase register was found not one-hot
//   retired  completed-instruction count
module phase_seq #(
    parameter int unsigned NPHASE = 5,
    parameter int unsigned CNTW   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              restart,
    input  logic [NPHASE-1:0] skip,
    output logic [NPHASE-1:0] phase,
    output logic              first,
    output logic              last,
    output logic              err,
    output logic [CNTW-1:0]   retired
);

    localparam logic [NPHASE-1:0] PH0 = NPHASE'(1);

    logic              onehot;
    logic              wrap;
    logic [NPHASE-1:0] adv;
    int unsigned       cur_idx;
    logic              skip_unused;

    // Phase 0 is never skipped; the decoder's bit 0 carries no meaning.
    assign skip_unused = skip[0];

    assign onehot = (phase != '0) && ((phase & (phase - PH0)) == '0);

    // Advance target: lowest unskipped phase above the current one,
    // otherwise wrap to phase 0.
    always_comb begin
        cur_idx = 0;
        for (int unsigned i = 0; i < NPHASE; i++) begin
            if (phase[i]) begin
                cur_idx = i;
            end
        end
        adv  = PH0;
        wrap = 1'b1;
        for (int unsigned j = 1; j < NPHASE; j++) begin
            if (wrap && (j > cur_idx) && !skip[j]) begin
                adv    = '0;
                adv[j] = 1'b1;
                wrap   = 1'b0;
            end
        end
    end

    assign first = phase[0];
    assign last  = !rst && !stall && !restart && onehot && wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH0;
            err   <= 1'b0;
        end else if (!onehot) begin
            phase <= PH0;
            err   <= 1'b1;
        end else if (restart) begin
            phase <= PH0;
        end else if (!stall) begin
            phase <= adv;
        end
    end

`ifdef PHASE_SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (last) begin
            retired <= retired + CNTW'(1);
        end
    end
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq -- directed self-checking bench for phase_seq (NPHASE=5, CNTW=4).
module tb_phase_seq;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       restart;
    logic [4:0] skip;
    logic [4:0] phase;
    logic       first;
    logic       last;
    logic       err;
    logic [3:0] retired;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [3:0]  exp_ret = '0;

`ifdef PHASE_SEQ_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    phase_seq #(.NPHASE(5), .CNTW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .stall   (stall),
        .restart (restart),
        .skip    (skip),
        .phase   (phase),
        .first   (first),
        .last    (last),
        .err     (err),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Apply inputs, check the pre-edge state and outputs, then take one edge.
    task automatic step(input string tag, input logic st, input logic rs,
                        input logic [4:0] sk, input logic [4:0] ep,
                        input logic el, input logic ee);
        stall   = st;
        restart = rs;
        skip    = sk;
        #2;
        chk({tag, " phase"},   {27'd0, phase},   {27'd0, ep});
        chk({tag, " first"},   {31'd0, first},   {31'd0, ep[0]});
        chk({tag, " last"},    {31'd0, last},    {31'd0, el});
        chk({tag, " err"},     {31'd0, err},     {31'd0, ee});
        chk({tag, " retired"}, {28'd0, retired}, {28'd0, exp_ret});
        if (CNT_EN && el) exp_ret = exp_ret + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst     = 1'b1;
        stall   = 1'b0;
        restart = 1'b0;
        skip    = '0;
        @(posedge clk);
        #1;
        chk("rst last", {31'd0, last}, 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        exp_ret = '0;
    endtask

    initial begin
        do_reset();

        // free run, no skips
        step("run0", 0, 0, 5'b00000, 5'b00001, 0, 0);
        step("run1", 0, 0, 5'b00000, 5'b00010, 0, 0);
        step("run2", 0, 0, 5'b00000, 5'b00100, 0, 0);
        step("run3", 0, 0, 5'b00000, 5'b01000, 0, 0);
        step("run4", 0, 0, 5'b00000, 5'b10000, 1, 0);
        step("run5", 0, 0, 5'b00000, 5'b00001, 0, 0);

        // skip memory phase
        step("skm0", 0, 0, 5'b01000, 5'b00010, 0, 0);
        step("skm1", 0, 0, 5'b01000, 5'b00100, 0, 0);
        step("skm2", 0, 0, 5'b01000, 5'b10000, 1, 0);
        step("skm3", 0, 0, 5'b01000, 5'b00001, 0, 0);
        step("skm4", 0, 0, 5'b01000, 5'b00010, 0, 0);
        step("skm5", 0, 0, 5'b01000, 5'b00100, 0, 0);
        step("skm6", 0, 0, 5'b01000, 5'b10000, 1, 0);

        // stall three cycles in phase 4
        step("stl0", 0, 0, 5'b00000, 5'b00001, 0, 0);
        step("stl1", 0, 0, 5'b00000, 5'b00010, 0, 0);
        step("stl2", 1, 0, 5'b00000, 5'b00100, 0, 0);
        step("stl3", 1, 0, 5'b00000, 5'b00100, 0, 0);
        step("stl4", 1, 0, 5'b00000, 5'b00100, 0, 0);
        step("stl5", 0, 0, 5'b00000, 5'b00100, 0, 0);

        // restart with simultaneous stall in phase 8
        step("rsa0", 1, 1, 5'b00000, 5'b01000, 0, 0);
        step("rsa1", 0, 0, 5'b00000, 5'b00001, 0, 0);
        // restart in phase 2, then while already in phase 0
        step("rsb0", 0, 1, 5'b00000, 5'b00010, 0, 0);
        step("rsb1", 0, 1, 5'b00000, 5'b00001, 0, 0);
        step("rsb2", 0, 0, 5'b00000, 5'b00001, 0, 0);
        // restart in the final phase is not a completion
        step("rsc0", 0, 0, 5'b00000, 5'b00010, 0, 0);
        step("rsc1", 0, 0, 5'b00000, 5'b00100, 0, 0);
        step("rsc2", 0, 0, 5'b00000, 5'b01000, 0, 0);
        step("rsc3", 0, 1, 5'b00000, 5'b10000, 0, 0);

        // single-phase instructions
        step("one0", 0, 0, 5'b11110, 5'b00001, 1, 0);
        step("one1", 0, 0, 5'b11110, 5'b00001, 1, 0);
        step("one2", 0, 0, 5'b10111, 5'b00001, 0, 0);
        step("one3", 0, 0, 5'b10111, 5'b01000, 1, 0);

        // corrupted phase register: recovery beats stall, err is sticky
        stall   = 1'b0;
        restart = 1'b0;
        skip    = 5'b11110;
        force dut.phase = 5'b00110;
        #2;
        chk("ill last", {31'd0, last},  32'd0);
        chk("ill first", {31'd0, first}, 32'd0);
        chk("ill err0", {31'd0, err},   32'd0);
        @(posedge clk);
        #1;
        release dut.phase;
        stall = 1'b1;
        #1;
        chk("ill err1", {31'd0, err}, 32'd1);
        chk("ill last1", {31'd0, last}, 32'd0);
        @(posedge clk);
        #1;
        step("err0", 0, 0, 5'b00000, 5'b00001, 0, 1);
        step("err1", 0, 0, 5'b00000, 5'b00010, 0, 1);
        step("err2", 0, 0, 5'b00000, 5'b00100, 0, 1);
        step("err3", 0, 0, 5'b00000, 5'b01000, 0, 1);
        step("err4", 0, 0, 5'b00000, 5'b10000, 1, 1);
        step("err5", 0, 0, 5'b00000, 5'b00001, 0, 1);
        step("err6", 0, 0, 5'b00000, 5'b00010, 0, 1);
        step("err7", 0, 0, 5'b00000, 5'b00100, 0, 1);
        step("err8", 0, 0, 5'b00000, 5'b01000, 0, 1);
        step("err9", 0, 0, 5'b00000, 5'b10000, 1, 1);

        do_reset();
        step("clr", 0, 0, 5'b00000, 5'b00001, 0, 0);
        step("clr1", 0, 0, 5'b00000, 5'b00010, 0, 0);
        do_reset();

        // 17 single-phase instructions: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            step("wrap", 0, 0, 5'b11110, 5'b00001, 1, 0);
        end
        stall = 1'b1;
        #2;
        chk("wrap final", {28'd0, retired}, CNT_EN ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
